// File: rtl/digdug_hvgen_if.sv
// Video timing bundle driven by digdug_hvgen.
//   PCLK_EN : one-cycle pixel enable (1 of every 8 master clocks)
//   POSH    : horizontal pixel position
//   POSV    : vertical line position
//   HBLK    : horizontal blank
//   VBLK    : vertical blank
//   HSYNC   : horizontal sync, active high
//   VSYNC   : vertical sync, active high
//   VBIRQ   : one-pixel pulse at the first pixel of vertical blank
//   FRAME   : frame counter, advances with VBIRQ
// master = timing generator, slave = consumer.
interface digdug_hvgen_if;
   logic       PCLK_EN;
   logic [8:0] POSH;
   logic [8:0] POSV;
   logic       HBLK;
   logic       VBLK;
   logic       HSYNC;
   logic       VSYNC;
   logic       VBIRQ;
   logic [7:0] FRAME;

   modport master (
      output PCLK_EN, POSH, POSV, HBLK, VBLK, HSYNC, VSYNC, VBIRQ, FRAME
   );

   modport slave (
      input PCLK_EN, POSH, POSV, HBLK, VBLK, HSYNC, VSYNC, VBIRQ, FRAME
   );
endinterface

// File: rtl/digdug_hvgen.sv
// Horizontal/vertical video timing generator.
//   CLK48M : master clock, sole clock of the block
//   RESET  : synchronous, active-high reset
//   vid    : timing outputs (see digdug_hvgen_if)
// A 3-bit divider yields a pixel enable every 8th master clock. POSH runs
// H_START..H_END and never shows values below H_START; POSV advances when POSH
// wraps. Blank/sync/irq flags are registered from the next-state counters so
// they line up exactly with the POSH/POSV outputs.
module digdug_hvgen #(
   parameter logic [8:0] H_START  = 9'd128,
   parameter logic [8:0] H_END    = 9'd511,
   parameter logic [8:0] V_TOTAL  = 9'd264,
   parameter logic [8:0] HB_START = 9'd416,
   parameter logic [8:0] HS_START = 9'd440,
   parameter logic [8:0] HS_END   = 9'd471,
   parameter logic [8:0] VB_START = 9'd224,
   parameter logic [8:0] VS_START = 9'd232,
   parameter logic [8:0] VS_END   = 9'd239
) (
   input  logic          CLK48M,
   input  logic          RESET,
   digdug_hvgen_if.master vid
);

   logic [2:0] div_q;
   logic       pclk_en;
   logic       h_wrap;
   logic [8:0] posh_q, posh_d;
   logic [8:0] posv_q, posv_d;
   logic       hblk_q, vblk_q, hsync_q, vsync_q, vbirq_q;
   logic       hblk_d, vblk_d, hsync_d, vsync_d, vbirq_d;
   logic [7:0] frame_q;

   always_comb begin
      pclk_en = (div_q == 3'd7);
      h_wrap  = (posh_q == H_END);
      posh_d  = h_wrap ? H_START : posh_q + 9'd1;
      posv_d  = posv_q;
      if (h_wrap) begin
         // >= guard keeps POSV in range even if the register were ever corrupted
         posv_d = (posv_q >= V_TOTAL - 9'd1) ? 9'd0 : posv_q + 9'd1;
      end
      hblk_d  = (posh_d >= HB_START);
      vblk_d  = (posv_d >= VB_START);
      hsync_d = (posh_d >= HS_START) && (posh_d <= HS_END);
      vsync_d = (posv_d >= VS_START) && (posv_d <= VS_END);
      vbirq_d = (posv_d == VB_START) && (posh_d == H_START);
   end

   always_ff @(posedge CLK48M) begin
      if (RESET) begin
         div_q   <= 3'd0;
         posh_q  <= H_START;
         posv_q  <= 9'd0;
         hblk_q  <= 1'b0;
         vblk_q  <= 1'b0;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
         vbirq_q <= 1'b0;
         frame_q <= 8'd0;
      end else begin
         div_q <= div_q + 3'd1;
         if (pclk_en) begin
            posh_q  <= posh_d;
            posv_q  <= posv_d;
            hblk_q  <= hblk_d;
            vblk_q  <= vblk_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            vbirq_q <= vbirq_d;
            if (vbirq_d) begin
               frame_q <= frame_q + 8'd1;
            end
         end
      end
   end

   assign vid.PCLK_EN = pclk_en;
   assign vid.POSH    = posh_q;
   assign vid.POSV    = posv_q;
   assign vid.HBLK    = hblk_q;
   assign vid.VBLK    = vblk_q;
   assign vid.HSYNC   = hsync_q;
   assign vid.VSYNC   = vsync_q;
   assign vid.VBIRQ   = vbirq_q;
   assign vid.FRAME   = frame_q;

endmodule

// File: doc/digdug_hvgen.md
DIGDUG_HVGEN -- requirements
Module: digdug_hvgen

Interface
REQ-001 Parameter H_START, 9'd128, first horizontal count value of a line.
REQ-002 Parameter H_END, 9'd511, last horizontal count value; line length = H_END-H_START+1 = 384 pixels.
REQ-003 Parameter V_TOTAL, 9'd264, lines per frame; vertical count runs 0..V_TOTAL-1.
REQ-004 Parameter HB_START, 9'd416, first POSH value of horizontal blank; visible POSH 128..415 (288 px).
REQ-005 Parameter HS_START / HS_END, 9'd440 / 9'd471, inclusive POSH range of HSYNC.
REQ-006 Parameter VB_START, 9'd224, first blanked line; visible lines 0..223.
REQ-007 Parameter VS_START / VS_END, 9'd232 / 9'd239, inclusive POSV range of VSYNC.
REQ-008 CLK48M  in  1  master clock, 48 MHz; sole clock.
REQ-009 RESET  in  1  synchronous, active-high reset.
REQ-010 PCLK_EN  out  1  one-CLK48M-cycle pixel enable, 6 MHz rate.
REQ-011 POSH  out  9  horizontal pixel position, H_START..H_END.
REQ-012 POSV  out  9  vertical line position, 0..V_TOTAL-1.
REQ-013 HBLK  out  1  horizontal blank, high when POSH>=HB_START.
REQ-014 VBLK  out  1  vertical blank, high when POSV>=VB_START.
REQ-015 HSYNC  out  1  active-high horizontal sync.
REQ-016 VSYNC  out  1  active-high vertical sync.
REQ-017 VBIRQ  out  1  one-pixel-wide pulse at start of vertical blank.
REQ-018 FRAME  out  8  frame counter.

Function
REQ-019 3-bit divider increments every CLK48M cycle, wraps 7->0; PCLK_EN high exactly when divider==7.
REQ-020 All counters/outputs except PCLK_EN and the divider update only on CLK48M edges with PCLK_EN high.
REQ-021 POSH increments by 1 per pixel; at H_END next value is H_START (511->128 wrap, no 0..127 values ever output).
REQ-022 POSV increments only on the pixel where POSH wraps H_END->H_START; at V_TOTAL-1 with wrap, POSV->0.
REQ-023 POSV therefore changes in the same cycle POSH becomes H_START; POSH>=504 marks the last 8 pixels before POSV advance.
REQ-024 HBLK, VBLK, HSYNC, VSYNC are registered, decoded from the next POSH/POSV values, so they are aligned with the POSH/POSV outputs (zero relative latency).
REQ-025 VBIRQ high for exactly one pixel (8 CLK48M cycles) when POSV==VB_START and POSH==H_START; low otherwise.
REQ-026 FRAME increments (mod 256, 255->0) on the same pixel VBIRQ asserts.
REQ-027 Counter arithmetic 9-bit unsigned; no out-of-range value (POSH<H_START, POSV>=V_TOTAL) shall ever appear.
REQ-028 Frame period = 384x264x8 = 811008 CLK48M cycles; line period = 3072 CLK48M cycles.

Reset
REQ-029 While RESET high at a CLK48M edge: divider=0, PCLK_EN=0, POSH=H_START, POSV=0, HBLK=0, VBLK=0, HSYNC=0, VSYNC=0, VBIRQ=0, FRAME=0.
REQ-030 Reset takes priority over PCLK_EN and any pending wrap; mid-frame reset restarts at POSH=128, POSV=0 with no VBIRQ generated.
REQ-031 After RESET falls, first PCLK_EN occurs on the 8th CLK48M edge; first POSH advance (128->129) on that edge.

Verification
REQ-032 Release reset, count cycles -> PCLK_EN period 8, first pulse 8 edges after release, POSH 128->129 there.
REQ-033 Run one line -> POSH sequence 128..511 then 128; HBLK high 416..511; HSYNC high 440..471 (32 px); POSV +1 at wrap.
REQ-034 Run to POSV=263, POSH=511 -> next pixel POSV=0, POSH=128; VBLK high lines 224..263; VSYNC high lines 232..239.
REQ-035 Run 2 frames -> exactly 2 VBIRQ pulses, each 8 CLK48M cycles, 811008 cycles apart, at POSV=224/POSH=128; FRAME 0->1->2.
REQ-036 Preload FRAME=255 by running 255 frames (or force) -> next VBIRQ sets FRAME=0.
REQ-037 Assert RESET for 1 cycle at POSV=224, POSH=128 coincident with PCLK_EN -> VBIRQ stays 0, outputs equal REQ-029 values next cycle.
